// File: rtl/data_pipe_pkg.sv
// Shared definitions for the data_pipe interconnect family: pipe occupancy
// states and the path-select width helper.
package data_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMPTY = 2'd1,
        ONE   = 2'd2,
        TWO   = 2'd3
    } pipe_state_e;

    // Width of a path index able to address num downstream channels.
    function automatic int nsize_f(input int num);
        if (num <= 2)       return 1;
        else if (num <= 4)  return 2;
        else if (num <= 8)  return 3;
        else if (num <= 16) return 4;
        else                return 5;
    endfunction

endpackage

// File: rtl/data_pipe_skid2.sv
// Generic 2-entry pipe stage: connector register plus one skid buffer,
// with a registered upstream ready gated by vld_sw.
module data_pipe_skid2
    import data_pipe_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             vld_sw,
    input  logic             in_valid,
    input  logic [DSIZE-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [DSIZE-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       state_dbg,
    output logic [1:0]       nstate_dbg
);

    // Handshake: a beat moves on an edge where valid & ready & clk_en are all
    // high; valid never waits for ready, ready may depend only on registers.
    pipe_state_e      state_q, state_d;
    logic [DSIZE-1:0] conn_q, conn_d;
    logic [DSIZE-1:0] buf_q, buf_d;
    logic             ready_q, ready_d;
    logic             conn_vld;
    logic             up_hs;
    logic             dn_hs;

    always_comb begin
        conn_vld = (state_q == ONE) || (state_q == TWO);
        up_hs    = in_valid & ready_q & clk_en;
        dn_hs    = conn_vld & out_ready & clk_en;
        state_d  = state_q;
        conn_d   = conn_q;
        buf_d    = buf_q;
        case (state_q)
            IDLE:  state_d = EMPTY;
            EMPTY: begin
                if (up_hs) begin
                    state_d = ONE;
                    conn_d  = in_data;
                end
            end
            ONE: begin
                if (up_hs && !dn_hs) begin
                    state_d = TWO;
                    buf_d   = in_data;
                end else if (!up_hs && dn_hs) begin
                    state_d = EMPTY;
                end else if (up_hs && dn_hs) begin
                    conn_d = in_data;
                end
            end
            TWO: begin
                if (dn_hs) begin
                    state_d = ONE;
                    conn_d  = buf_q;
                    buf_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Ready stays low through the IDLE cycle so it only loads once EMPTY
        // is reached; it can fall without clk_en but never rises.
        ready_d = 1'b0;
        if (state_q != IDLE && (state_d == EMPTY || state_d == ONE)) begin
            ready_d = clk_en ? vld_sw : (ready_q & vld_sw);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= IDLE;
            conn_q  <= '0;
            buf_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            conn_q  <= conn_d;
            buf_q   <= buf_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready   = ready_q;
    assign out_valid  = conn_vld;
    assign out_data   = conn_q;
    assign state_dbg  = state_q;
    assign nstate_dbg = state_d;

endmodule

// File: rtl/data_pipe_interconnect_s2m.sv
// One upstream stream fanned out to NUM downstream channels; the path is
// latched only while the pipe is empty so a beat never splits across paths.
module data_pipe_interconnect_s2m
    import data_pipe_pkg::*;
#(
    parameter int NUM   = 8,
    parameter int DSIZE = 8,
    localparam int NSIZE = nsize_f(NUM)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             vld_sw,
    input  logic [NSIZE-1:0] sw,
    output logic [NSIZE-1:0] curr_path,
    input  logic             s00_valid,
    input  logic [DSIZE-1:0] s00_data,
    output logic             s00_ready,
    output logic [NUM-1:0]   m00_valid,
    output logic [DSIZE-1:0] m00_data,
    input  logic [NUM-1:0]   m00_ready,
    output logic [1:0]       dbg_state
);

    localparam logic [NSIZE:0] NUM_W = NUM[NSIZE:0];

    logic [NSIZE-1:0] curr_path_q, curr_path_d;
    logic             conn_vld;
    logic             sel_ready;
    logic [1:0]       nstate;

    data_pipe_skid2 #(.DSIZE(DSIZE)) u_skid (
        .clock      (clock),
        .rst        (rst),
        .clk_en     (clk_en),
        .vld_sw     (vld_sw),
        .in_valid   (s00_valid),
        .in_data    (s00_data),
        .in_ready   (s00_ready),
        .out_valid  (conn_vld),
        .out_data   (m00_data),
        .out_ready  (sel_ready),
        .state_dbg  (dbg_state),
        .nstate_dbg (nstate)
    );

    always_comb begin
        curr_path_d = curr_path_q;
        // Out-of-range requests (e.g. sw=1 with NUM=1) fall back to path 0.
        if (clk_en && (nstate == IDLE || nstate == EMPTY)) begin
            curr_path_d = ({1'b0, sw} < NUM_W) ? sw : '0;
        end
        sel_ready = m00_ready[curr_path_q];
        m00_valid = '0;
        m00_valid[curr_path_q] = conn_vld;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            curr_path_q <= '0;
        end else begin
            curr_path_q <= curr_path_d;
        end
    end

    assign curr_path = curr_path_q;

endmodule

// File: doc/data_pipe_interconnect_s2m.md
# data_pipe_interconnect_S2M

Single-slaver to multi-master pipe demultiplexer: one upstream `data_inf` stream is steered to one of `NUM` downstream `data_inf` masters chosen by `sw`. It is the fan-out counterpart of the many-to-one pipe interconnect and sits between a shared producer and per-channel consumers. It provides a registered, full-throughput 2-entry pipe (connector plus skid buffer). The path can only change when the pipe is empty, so a beat never splits across paths.

## Interface
- `NUM`, 8: number of downstream masters (1..32).
- `NSIZE`, derived (1 for NUM≤2, 2 for ≤4, 3 for ≤8, 4 for ≤16, else 5): width of `sw` and `curr_path`.
- `clock`  in  1  sole clock.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_en`  in  1  global enable; handshakes count only when high.
- `vld_sw`  in  1  switch valid; gates upstream ready.
- `sw`  in  NSIZE  requested path; sampled only while the pipe is empty.
- `curr_path`  out  NSIZE  path currently latched.
- `s00`  `data_inf.slaver`  DSIZE  upstream stream: valid, data, ready.
- `m00[NUM-1:0]`  `data_inf.master`  DSIZE  downstream streams. DSIZE is taken from `s00.DSIZE`.

## Operation
- Up handshake (`up_hs`) = `s00.valid & s00.ready & clk_en`.
- Down handshake (`dn_hs`) = `m00[curr_path].valid & m00[curr_path].ready & clk_en`.
- State machine, registered, advances only when `clk_en` is high (except IDLE):
  - IDLE → EMPTY unconditionally.
  - EMPTY: `up_hs` → ONE; otherwise stay.
  - ONE (connector valid): `up_hs & !dn_hs` → TWO; `!up_hs & dn_hs` → EMPTY; otherwise stay (both or neither).
  - TWO (connector and buffer valid): `dn_hs` → ONE and the buffer moves into the connector; otherwise stay.
  - Illegal encodings → IDLE.
- Data path:
  - `up_hs` in EMPTY, or in ONE together with `dn_hs`, loads the connector.
  - `up_hs` in ONE without `dn_hs` loads the buffer.
  - The buffer is cleared to 0 when it drains.
- `curr_path <= sw` on each clock where `nstate` is IDLE or EMPTY and `clk_en` is high; otherwise it holds.
- `s00.ready` is registered:
  - `nstate` ∈ {EMPTY, ONE} with `clk_en`: `s00.ready <= vld_sw`.
  - `nstate` ∈ {EMPTY, ONE} without `clk_en`: `s00.ready <= s00.ready & vld_sw`.
  - `nstate` ∈ {IDLE, TWO}: `s00.ready <= 0`.
- Skid rule: ready drops the cycle after the handshake that fills TWO. The buffer absorbs the one beat already in flight, so overflow is impossible by construction.
- Outputs:
  - `m00[k].valid = connector_vld & (k == curr_path)`.
  - `m00[k].data = connector` for every k (broadcast).
  - `m00[k].ready` is ignored when `k != curr_path`.

## Timing
- Reset values: state IDLE; `s00.ready=0`; all `m00[k].valid=0`; connector, buffer and `curr_path` all 0.
- First `s00.ready=1` appears no earlier than the 2nd clock after `rst` deasserts (IDLE → EMPTY, then the ready register loads).
- Latency: a beat accepted at edge N is on `m00[curr_path]` from cycle N+1.
- Throughput: 1 beat/cycle with downstream ready held high.
- Ordering is strictly FIFO; beats are never duplicated or dropped.
- Path change: the new `sw` takes effect one edge after the pipe reaches EMPTY. A beat accepted in EMPTY goes to the `curr_path` value present on that handshake cycle.
- `clk_en` low: state, data, valid and `curr_path` hold. Ready may fall (when `vld_sw` falls) but never rises.
- `vld_sw` low: ready falls on the next edge. Beats already in the pipe still drain.
- `rst` mid-transfer: the pipe is flushed; in-flight beats are discarded with no error flag.
- NUM=1: `sw` is 1 bit and a value of 1 is ignored (index clamped to 0).

## Structure
- Shared package `data_pipe_pkg`:
  - `pipe_state_e` enum {IDLE, EMPTY, ONE, TWO}, reused by the M2S variant on its next revision.
  - `nsize_f(NUM)` function.
- Optional sub-module `data_pipe_skid2`: the generic 2-entry connector/buffer with registered ready. The top level then adds only the path latch and the valid fan-out.
- RTL target is about 180 lines.

## Test plan
- Single beat: NUM=4, `sw=2`, `vld_sw=1`, one beat `0xA5`, all readies high → `m00[2].valid` high one cycle later with `0xA5`; other valids stay 0.
- Backpressure: `m00[1].ready=0`, upstream streams `1,2,3` → beats 1 and 2 are held, ready falls after beat 2, beat 3 waits. Releasing ready yields `1,2,3` in order with no loss.
- Path switch: send 3 beats on path 0, set `sw=3` mid-burst → remaining beats stay on path 0. Path 3 is used only after drain; `curr_path` reads 3 one edge after EMPTY.
- `clk_en` toggling every other cycle with streaming traffic → output order preserved, exactly 1 beat per enabled cycle.
- `vld_sw=0` while idle → `s00.ready` stays 0 and no valid appears. Raising it → ready=1 on the next edge.
- Reset asserted in TWO → the next cycle has all valids 0, `s00.ready=0` and `curr_path=0`. Ready returns 2 cycles after release.
